// File: rtl/add_seq_pkg.sv
// add_seq_pkg: shared state encoding and requester count for the sequential adder controller
package add_seq_pkg;
  localparam int NUM_REQ = 2;
  typedef enum logic [2:0] {IDLE, SUM, CARRY, RESP, NEXT} state_t;
endpackage

// File: rtl/add_seq_alu_add.sv
// alu_add: unsigned word adder with carry out
module alu_add #(
  parameter int WORD_WIDTH = 4
) (
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [WORD_WIDTH-1:0] b,
  output logic [WORD_WIDTH-1:0] sum,
  output logic                  cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: two-requester round-robin multi-word adder sharing one adder across sum and carry passes
module add_seq_ctrl
  import add_seq_pkg::*;
#(
  parameter int WORD_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rsp_valid,
  output logic [WORD_WIDTH-1:0]         rsp_sum,
  output logic                          rsp_cout,
  output logic                          rsp_last,
  output logic                          rsp_id,
  input  logic                          rsp_ready,
  output logic                          busy
);
  localparam int W = WORD_WIDTH;
  state_t state, nxt;
  logic ptr, carry, gnt, sel, take, id_q, last_q, c1, co;
  logic [W-1:0] a_q, b_q, s1, op_a, op_b, sum;
  always_comb begin
    gnt = req_valid[ptr] ? ptr : ~ptr;
    sel = state == IDLE ? gnt : id_q;
    take = !rst && (state == IDLE ? |req_valid : state == NEXT && req_valid[id_q]);
    req_ready = take ? (sel ? 2'b10 : 2'b01) : 2'b00;
    nxt = state == SUM ? CARRY :
          state == CARRY ? RESP :
          state == RESP ? (rsp_ready ? (rsp_last ? IDLE : NEXT) : RESP) :
          take ? SUM : state;
  end
  assign op_a = state == SUM ? a_q : s1;
  assign op_b = state == SUM ? b_q : W'(carry);
  assign busy = state != IDLE;
  assign rsp_valid = state == RESP;
  alu_add #(.WORD_WIDTH(W)) u_add (.a(op_a), .b(op_b), .sum(sum), .cout(co));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr <= 1'b0;
      carry <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      last_q <= 1'b0;
      id_q <= 1'b0;
      s1 <= '0;
      c1 <= 1'b0;
      rsp_sum <= '0;
      rsp_cout <= 1'b0;
      rsp_last <= 1'b0;
      rsp_id <= 1'b0;
    end else begin
      if (take) begin
        a_q <= sel ? req_a[2*W-1:W] : req_a[W-1:0];
        b_q <= sel ? req_b[2*W-1:W] : req_b[W-1:0];
        last_q <= req_last[sel];
        id_q <= sel;
      end
      if (take && state == IDLE) carry <= 1'b0;
      if (state == SUM) begin
        s1 <= sum;
        c1 <= co;
      end
      if (state == CARRY) begin
        rsp_sum <= sum;
        rsp_cout <= c1 | co;
        rsp_last <= last_q;
        rsp_id <= id_q;
      end
      if (state == RESP && rsp_ready) begin
        carry <= rsp_cout;
        if (rsp_last) ptr <= ~rsp_id;
      end
    end
endmodule

// File: doc/add_seq_ctrl.md
ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001: Parameter WORD_WIDTH, default 4, shall set the operand/result word width in bits.
REQ-002: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003: rst  input  1  reset, asynchronous and active-high.
REQ-004: req_valid  input  2  per-requester operand-word valid; bit i belongs to requester i.
REQ-005: req_a  input  2*WORD_WIDTH  operand A words; requester i in bits [i*W +: W].
REQ-006: req_b  input  2*WORD_WIDTH  operand B words; same packing as req_a.
REQ-007: req_last  input  2  marks the most-significant (final) word of requester i's transaction.
REQ-008: req_ready  output  2  one-hot or zero; accept strobe for requester i's current word.
REQ-009: rsp_valid  output  1  result word valid.
REQ-010: rsp_sum  output  WORD_WIDTH  result word.
REQ-011: rsp_cout  output  1  carry out of this word, including incoming carry.
REQ-012: rsp_last  output  1  result is the final word of the transaction.
REQ-013: rsp_id  output  1  requester that owns the result.
REQ-014: rsp_ready  input  1  downstream accepts the result.
REQ-015: busy  output  1  high in every state except IDLE.

Function
REQ-016: Words shall be added LSW first; a transaction runs from the first accepted word to the accepted word with req_last=1.
REQ-017: FSM states: IDLE, SUM, CARRY, RESP, NEXT; exactly one adder instance, time-shared between SUM and CARRY.
REQ-018: IDLE: if any req_valid, grant per round-robin pointer (pointer requester wins if both valid, otherwise the valid one), assert its req_ready combinationally, latch a/b/last/id, clear carry register, go to SUM.
REQ-019: SUM: adder inputs = latched a, b; latch partial sum s1 and c1; go to CARRY.
REQ-020: CARRY: adder inputs = s1 and zero-extended carry register; latch rsp_sum, rsp_cout = c1 OR c2; go to RESP.
REQ-021: RESP: rsp_valid=1; rsp_sum/cout/last/id shall hold stable until rsp_valid && rsp_ready.
REQ-022: On RESP handshake: carry register <= rsp_cout; if last, toggle pointer away from owner and go to IDLE; else go to NEXT.
REQ-023: NEXT: wait for the owner's req_valid only; on it assert owner's req_ready, latch a/b/last, go to SUM; the other requester shall receive no ready.
REQ-024: req_ready shall be asserted only in IDLE or NEXT and only with the matching req_valid high.
REQ-025: Latency: word accepted at edge t -> rsp_valid high after edge t+2 (third cycle); max throughput one word per 4 cycles.
REQ-026: Single-word transaction (req_last=1 on first word) shall use carry-in 0 and return to IDLE after one response.
REQ-027: Sum arithmetic is modulo 2^WORD_WIDTH; c1 and c2 shall never both be 1, so rsp_cout is exact.
REQ-028: A requester whose req_valid drops mid-transaction shall stall the FSM in NEXT indefinitely; no timeout.

Reset
REQ-029: rst asserted at any time shall immediately force IDLE, pointer=0, carry=0, rsp_valid=0, req_ready=0, busy=0, rsp_sum=0, rsp_cout=0, rsp_last=0, rsp_id=0.
REQ-030: An in-flight transaction shall be discarded on reset; no partial response emitted afterwards.

Structure
REQ-031: Shared package add_seq_pkg shall hold the state encoding constants and the requester count (2).
REQ-032: The adder shall be one instance of the existing alu_add sub-module, WORD_WIDTH passed through; add_seq_ctrl owns the input muxing.

Verification (WORD_WIDTH=4)
REQ-033: Single word req0 a=0x9 b=0x8 last=1 -> one response sum=0x1 cout=1 last=1 id=0, rsp_valid three cycles after accept.
REQ-034: Three-word req1 0xFFF+0x001 LSW first -> sums 0x0,0x0,0x0, couts 1,1,1, last only on third, id=1.
REQ-035: Carry via second pass: words (0xF,0x1) then (0xF,0x0) -> (0x0,c=1) then (0x0,c=1).
REQ-036: Both req_valid high after reset -> req0 served first, req1 next; req1 held off while req0 sits in NEXT.
REQ-037: rsp_ready low 5 cycles in RESP -> outputs stable, no new req_ready, resumes on rsp_ready.
REQ-038: rst pulsed while in CARRY -> all outputs zero, FSM in IDLE, next transaction starts with carry 0, pointer 0.
